// File: rtl/best_1ofn_cclut_pipe.sv
`default_nettype none
// ============================================================================
// Module   : best_1ofn_cclut_pipe
// Purpose  : Pipelined best-1-of-N selector for the ccLUT pattern finder.
//            One candidate (pattern, key, comparator code) per CFEB channel
//            is registered and qualified by the channel enable and the
//            pattern threshold. A registered binary comparison tree then
//            picks the best candidate. Latency is 1 + ceil(log2(NCH))
//            clocks, and one candidate set is accepted every clock.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clock       in   sole clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   cand_vld    in   candidate set valid this cycle
//   pat         in   NCH packed patterns, channel i at [i*MXPATB +: MXPATB]
//   key         in   NCH packed 1/2-strip keys, same packing
//   carry       in   NCH packed ccLUT comparator codes, same packing
//   ch_en       in   per-channel enable, sampled with cand_vld
//   pat_thresh  in   minimum sort key (quasi-static)
//   best_vld    out  a qualified winner is present
//   best_pat    out  winning pattern
//   best_key    out  {winning channel, winning key}
//   best_carry  out  winning comparator code
//   best_chan   out  winning channel index
// ============================================================================
module best_1ofn_cclut_pipe #(
    parameter int NCH        = 7,
    parameter int CHB        = 3,
    parameter int MXPATB     = 7,
    parameter int MXKEYB     = 5,
    parameter int MXPATC     = 11,
    parameter int MXKEYBX    = 8,
    parameter int IGNORE_LSB = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          cand_vld,
    input  logic [NCH*MXPATB-1:0]         pat,
    input  logic [NCH*MXKEYB-1:0]         key,
    input  logic [NCH*MXPATC-1:0]         carry,
    input  logic [NCH-1:0]                ch_en,
    input  logic [MXPATB-IGNORE_LSB-1:0]  pat_thresh,
    output logic                          best_vld,
    output logic [MXPATB-1:0]             best_pat,
    output logic [MXKEYBX-1:0]            best_key,
    output logic [MXPATC-1:0]             best_carry,
    output logic [CHB-1:0]                best_chan
);

    // Sort key width: the pattern with or without its bend-direction lsb.
    localparam int SKW = MXPATB - IGNORE_LSB;
    // Tree depth and the power-of-two leaf count it spans.
    localparam int LV  = $clog2(NCH);
    localparam int NP  = 1 << LV;

    // ------------------------------------------------------------------------
    // Configuration checks
    // ------------------------------------------------------------------------
    if (MXKEYBX != CHB + MXKEYB) begin : g_err_keybx
        $error("best_1ofn_cclut_pipe: MXKEYBX must equal CHB+MXKEYB");
    end
    if (NCH < 2 || NCH > 8) begin : g_err_nch
        $error("best_1ofn_cclut_pipe: NCH must be in 2..8");
    end
    if (CHB < LV || CHB < 1) begin : g_err_chb
        $error("best_1ofn_cclut_pipe: CHB too narrow for NCH");
    end
    if (IGNORE_LSB != 0 && IGNORE_LSB != 1) begin : g_err_lsb
        $error("best_1ofn_cclut_pipe: IGNORE_LSB must be 0 or 1");
    end

    // One tree node: qualification, sort key, payload and source channel.
    // An unqualified node is all zeros, so its payload can never leak out.
    typedef struct packed {
        logic              q;
        logic [SKW-1:0]    sk;
        logic [MXPATB-1:0] pat;
        logic [MXKEYB-1:0] key;
        logic [MXPATC-1:0] carry;
        logic [CHB-1:0]    chan;
    } node_t;

    // ------------------------------------------------------------------------
    // Stage 0: input registers. Enable and threshold are captured with the
    // set so that later changes never affect sets already in flight.
    // ------------------------------------------------------------------------
    logic                  vld_s0;
    logic [NCH*MXPATB-1:0] pat_s0;
    logic [NCH*MXKEYB-1:0] key_s0;
    logic [NCH*MXPATC-1:0] carry_s0;
    logic [NCH-1:0]        en_s0;
    logic [SKW-1:0]        thr_s0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_s0   <= 1'b0;
            pat_s0   <= '0;
            key_s0   <= '0;
            carry_s0 <= '0;
            en_s0    <= '0;
            thr_s0   <= '0;
        end else begin
            vld_s0   <= cand_vld;
            pat_s0   <= pat;
            key_s0   <= key;
            carry_s0 <= carry;
            en_s0    <= ch_en;
            thr_s0   <= pat_thresh;
        end
    end

    // ------------------------------------------------------------------------
    // Leaves: qualified candidates. Leaves beyond NCH are permanently
    // unqualified; as a B input they can never win and as an A input they
    // lose to any qualified partner, so an odd leftover node simply passes
    // through each level registered and unchanged.
    // ------------------------------------------------------------------------
    for (genvar j = 0; j < NP; j++) begin : g_leaf
        node_t lf;
        if (j < NCH) begin : g_chan
            logic [SKW-1:0] sk;
            logic           qual;
            if (IGNORE_LSB != 0) begin : g_skip_lsb
                assign sk = pat_s0[j*MXPATB+1 +: SKW];
            end else begin : g_full_pat
                assign sk = pat_s0[j*MXPATB +: SKW];
            end
            assign qual = vld_s0 & en_s0[j] & (sk >= thr_s0) & (sk != '0);
            assign lf   = qual ? {1'b1, sk,
                                  pat_s0[j*MXPATB +: MXPATB],
                                  key_s0[j*MXKEYB +: MXKEYB],
                                  carry_s0[j*MXPATC +: MXPATC],
                                  CHB'(j)}
                               : '0;
        end else begin : g_pad
            assign lf = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Comparison tree in heap order: node i has children 2i+1 (lower
    // channels) and 2i+2 (higher channels). Indices NP-1 and up are leaves.
    // B wins only with a strictly larger key, which makes equal keys resolve
    // to the lowest channel across the whole tree.
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NP-1; i++) begin : g_node
        node_t a;
        node_t b;
        logic  b_wins;

        if (2*i+1 >= NP-1) begin : g_from_leaf
            assign a = g_leaf[2*i+1-(NP-1)].lf;
            assign b = g_leaf[2*i+2-(NP-1)].lf;
        end else begin : g_from_node
            assign a = g_node[2*i+1].g_mid.q;
            assign b = g_node[2*i+2].g_mid.q;
        end

        assign b_wins = b.q & (~a.q | (b.sk > a.sk));

        if (i == 0) begin : g_root
            // Root level registers are the outputs themselves.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    best_vld   <= 1'b0;
                    best_pat   <= '0;
                    best_key   <= '0;
                    best_carry <= '0;
                    best_chan  <= '0;
                end else begin
                    best_vld   <= b_wins ? b.q     : a.q;
                    best_pat   <= b_wins ? b.pat   : a.pat;
                    best_key   <= b_wins ? {b.chan, b.key} : {a.chan, a.key};
                    best_carry <= b_wins ? b.carry : a.carry;
                    best_chan  <= b_wins ? b.chan  : a.chan;
                end
            end
        end else begin : g_mid
            node_t q;
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    q <= '0;
                end else begin
                    q <= b_wins ? b : a;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_best_1ofn_cclut_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_best_1ofn_cclut_pipe
// Purpose  : Self-checking bench for best_1ofn_cclut_pipe. Five instances
//            (NCH=7 with and without lsb ignore, NCH=2, 5, 8) share one
//            8-channel stimulus bus; a linear-scan reference model gives
//            expected results.
// Revision : 1.0  initial release
// ============================================================================
module tb_best_1ofn_cclut_pipe;

    typedef struct packed {
        logic        vld;
        logic [6:0]  pat;
        logic [7:0]  key;
        logic [10:0] carry;
        logic [2:0]  chan;
    } res_t;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b1;
    logic        cand_vld = 1'b0;
    logic [55:0] pat      = '0;
    logic [39:0] key      = '0;
    logic [87:0] carry    = '0;
    logic [7:0]  ch_en    = '0;
    logic [6:0]  thr      = '0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // ---------------- DUT outputs ----------------
    logic o7_vld; logic [6:0] o7_pat; logic [7:0] o7_key; logic [10:0] o7_carry; logic [2:0] o7_chan;
    logic oz_vld; logic [6:0] oz_pat; logic [7:0] oz_key; logic [10:0] oz_carry; logic [2:0] oz_chan;
    logic o2_vld; logic [6:0] o2_pat; logic [5:0] o2_key; logic [10:0] o2_carry; logic [0:0] o2_chan;
    logic o5_vld; logic [6:0] o5_pat; logic [7:0] o5_key; logic [10:0] o5_carry; logic [2:0] o5_chan;
    logic o8_vld; logic [6:0] o8_pat; logic [7:0] o8_key; logic [10:0] o8_carry; logic [2:0] o8_chan;

    best_1ofn_cclut_pipe #(.NCH(7), .CHB(3), .MXKEYBX(8), .IGNORE_LSB(1)) u_d7 (
        .clock(clock), .reset_n(reset_n), .cand_vld(cand_vld),
        .pat(pat[48:0]), .key(key[34:0]), .carry(carry[76:0]), .ch_en(ch_en[6:0]),
        .pat_thresh(thr[5:0]),
        .best_vld(o7_vld), .best_pat(o7_pat), .best_key(o7_key),
        .best_carry(o7_carry), .best_chan(o7_chan));

    best_1ofn_cclut_pipe #(.NCH(7), .CHB(3), .MXKEYBX(8), .IGNORE_LSB(0)) u_dz (
        .clock(clock), .reset_n(reset_n), .cand_vld(cand_vld),
        .pat(pat[48:0]), .key(key[34:0]), .carry(carry[76:0]), .ch_en(ch_en[6:0]),
        .pat_thresh(thr[6:0]),
        .best_vld(oz_vld), .best_pat(oz_pat), .best_key(oz_key),
        .best_carry(oz_carry), .best_chan(oz_chan));

    best_1ofn_cclut_pipe #(.NCH(2), .CHB(1), .MXKEYBX(6), .IGNORE_LSB(1)) u_d2 (
        .clock(clock), .reset_n(reset_n), .cand_vld(cand_vld),
        .pat(pat[13:0]), .key(key[9:0]), .carry(carry[21:0]), .ch_en(ch_en[1:0]),
        .pat_thresh(thr[5:0]),
        .best_vld(o2_vld), .best_pat(o2_pat), .best_key(o2_key),
        .best_carry(o2_carry), .best_chan(o2_chan));

    best_1ofn_cclut_pipe #(.NCH(5), .CHB(3), .MXKEYBX(8), .IGNORE_LSB(1)) u_d5 (
        .clock(clock), .reset_n(reset_n), .cand_vld(cand_vld),
        .pat(pat[34:0]), .key(key[24:0]), .carry(carry[54:0]), .ch_en(ch_en[4:0]),
        .pat_thresh(thr[5:0]),
        .best_vld(o5_vld), .best_pat(o5_pat), .best_key(o5_key),
        .best_carry(o5_carry), .best_chan(o5_chan));

    best_1ofn_cclut_pipe #(.NCH(8), .CHB(3), .MXKEYBX(8), .IGNORE_LSB(1)) u_d8 (
        .clock(clock), .reset_n(reset_n), .cand_vld(cand_vld),
        .pat(pat), .key(key), .carry(carry), .ch_en(ch_en),
        .pat_thresh(thr[5:0]),
        .best_vld(o8_vld), .best_pat(o8_pat), .best_key(o8_key),
        .best_carry(o8_carry), .best_chan(o8_chan));

    // ---------------- instance tables ----------------
    function automatic int n_of(input int id);
        case (id)
            0, 1:    return 7;
            2:       return 2;
            3:       return 5;
            default: return 8;
        endcase
    endfunction

    function automatic bit ign_of(input int id);
        return (id != 1);
    endfunction

    // Required latency 1 + ceil(log2(NCH)).
    function automatic int lat_of(input int id);
        return (id == 2) ? 2 : 4;
    endfunction

    function automatic res_t observed(input int id);
        case (id)
            0:       return {o7_vld, o7_pat, o7_key, o7_carry, o7_chan};
            1:       return {oz_vld, oz_pat, oz_key, oz_carry, oz_chan};
            2:       return {o2_vld, o2_pat, 2'b00, o2_key, o2_carry, 2'b00, o2_chan};
            3:       return {o5_vld, o5_pat, o5_key, o5_carry, o5_chan};
            default: return {o8_vld, o8_pat, o8_key, o8_carry, o8_chan};
        endcase
    endfunction

    // Reference: scan channels in order and keep the first strictly larger
    // qualified sort key.
    function automatic res_t model(input int n, input bit ign, input logic v,
                                   input logic [55:0] p, input logic [39:0] k,
                                   input logic [87:0] c, input logic [7:0] en,
                                   input logic [6:0] th);
        res_t r;
        int   best;
        int   bsk;
        int   sk;
        int   t;
        r    = '0;
        best = -1;
        bsk  = 0;
        t    = ign ? int'(th[5:0]) : int'(th);
        for (int i = 0; i < n; i++) begin
            sk = ign ? int'(p[i*7+1 +: 6]) : int'(p[i*7 +: 7]);
            if (v && en[i] && sk >= t && sk != 0 && (best < 0 || sk > bsk)) begin
                best = i;
                bsk  = sk;
            end
        end
        if (best >= 0) begin
            r.vld   = 1'b1;
            r.pat   = p[best*7 +: 7];
            r.key   = 8'(best * 32 + int'(k[best*5 +: 5]));
            r.carry = c[best*11 +: 11];
            r.chan  = 3'(best);
        end
        return r;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic fill_random(input int maxpat);
        for (int i = 0; i < 8; i++) begin
            pat[i*7 +: 7]    = 7'($urandom_range(0, maxpat));
            key[i*5 +: 5]    = 5'($urandom);
            carry[i*11 +: 11] = 11'($urandom);
        end
    endtask

    task automatic set_sort_keys(input int s0, input int s1, input int s2, input int s3,
                                 input int s4, input int s5, input int s6, input int s7);
        int sk[8];
        sk = '{s0, s1, s2, s3, s4, s5, s6, s7};
        for (int i = 0; i < 8; i++) begin
            pat[i*7 +: 7] = {6'(sk[i]), 1'($urandom)};
        end
    endtask

    task automatic fire_and_wait(input int lat);
        @(posedge clock);
        #1 cand_vld = 1'b0;
        repeat (lat - 1) @(posedge clock);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        res_t obs;
        res_t exp;
        res_t zero_r;
        zero_r = '0;
        #2 reset_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            fill_random(127);
            pat[6:0] = 7'h7F; ch_en = 8'hFF; thr = '0; cand_vld = 1'b1;
            @(posedge clock);
            #1 obs = observed(0);
            checks++;
            if (obs !== zero_r) begin
                errors++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", c, obs, zero_r);
            end
        end
        @(negedge clock);
        cand_vld = 1'b0;
        reset_n  = 1'b1;
        // stream qualifying sets, then reset asynchronously mid-stream
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            fill_random(127);
            pat[6:0] = 7'h7F; ch_en = 8'hFF; cand_vld = 1'b1;
            @(posedge clock);
        end
        #1 obs = observed(0);
        checks++;
        if (obs.vld !== 1'b1) begin
            errors++;
            $display("FAIL prereset_vld got=%b exp=1", obs.vld);
        end
        #2 reset_n = 1'b0;
        #1 obs = observed(0);
        checks++;
        if (obs !== zero_r) begin
            errors++;
            $display("FAIL async_reset got=%h exp=%h", obs, zero_r);
        end
        @(negedge clock);
        fill_random(127);
        @(negedge clock);
        cand_vld = 1'b0;
        reset_n  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1 obs = observed(0);
            checks++;
            if (obs !== zero_r) begin
                errors++;
                $display("FAIL flush_after_reset cyc=%0d got=%h exp=%h", c, obs, zero_r);
            end
        end
        // first set after release: valid exactly 4 edges later
        @(negedge clock);
        fill_random(127);
        pat[6:0] = 7'h7F; ch_en = 8'hFF; thr = '0; cand_vld = 1'b1;
        exp = model(7, 1'b1, 1'b1, pat, key, carry, ch_en, thr);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clock);
            #1;
            if (e == 1) cand_vld = 1'b0;
            obs = observed(0);
            checks++;
            if (obs !== ((e == 4) ? exp : zero_r)) begin
                errors++;
                $display("FAIL first_latency edge=%0d got=%h exp=%h", e, obs,
                         (e == 4) ? exp : zero_r);
            end
        end
    endtask

    task automatic test_basic_select();
        @(negedge clock);
        fill_random(127);
        set_sort_keys(3, 9, 2, 9, 0, 5, 1, 0);
        pat[7] = 1'b0; pat[21] = 1'b1;   // ch3 has the larger raw pattern
        ch_en = 8'hFF; thr = '0; cand_vld = 1'b1;
        fire_and_wait(4);
        checks++;
        if (o7_vld !== 1'b1 || o7_chan !== 3'd1) begin
            errors++;
            $display("FAIL basic_chan got vld=%b chan=%0d exp vld=1 chan=1", o7_vld, o7_chan);
        end
        checks++;
        if (o7_key !== {3'd1, key[9:5]} || o7_carry !== carry[21:11] || o7_pat !== pat[13:7]) begin
            errors++;
            $display("FAIL basic_data got key=%h carry=%h pat=%h exp key=%h carry=%h pat=%h",
                     o7_key, o7_carry, o7_pat, {3'd1, key[9:5]}, carry[21:11], pat[13:7]);
        end
    endtask

    task automatic test_mask_thresh();
        res_t zero_r;
        zero_r = '0;
        @(negedge clock);
        ch_en = 8'b0111_1101; thr = 7'd6; cand_vld = 1'b1;
        fire_and_wait(4);
        checks++;
        if (o7_vld !== 1'b1 || o7_chan !== 3'd3 || o7_key !== {3'd3, key[19:15]} ||
            o7_carry !== carry[43:33]) begin
            errors++;
            $display("FAIL mask_thresh got vld=%b chan=%0d key=%h exp vld=1 chan=3 key=%h",
                     o7_vld, o7_chan, o7_key, {3'd3, key[19:15]});
        end
        @(negedge clock);
        thr = 7'd10; cand_vld = 1'b1;
        fire_and_wait(4);
        checks++;
        if (observed(0) !== zero_r) begin
            errors++;
            $display("FAIL thresh_none got=%h exp=%h", observed(0), zero_r);
        end
    endtask

    task automatic test_tie_lsb();
        @(negedge clock);
        set_sort_keys(3, 9, 2, 9, 0, 5, 1, 0);
        pat[20:14] = 7'h2B; pat[41:35] = 7'h2A;
        ch_en = 8'hFF; thr = '0; cand_vld = 1'b1;
        fire_and_wait(4);
        checks++;
        if (o7_chan !== 3'd2 || o7_pat !== 7'h2B) begin
            errors++;
            $display("FAIL tie_ignore_lsb got chan=%0d pat=%h exp chan=2 pat=2b", o7_chan, o7_pat);
        end
        @(negedge clock);
        pat[20:14] = 7'h2A; pat[41:35] = 7'h2B; cand_vld = 1'b1;
        fire_and_wait(4);
        checks++;
        if (oz_chan !== 3'd5 || oz_pat !== 7'h2B) begin
            errors++;
            $display("FAIL full_pat_lsb got chan=%0d pat=%h exp chan=5 pat=2b", oz_chan, oz_pat);
        end
        checks++;
        if (o7_chan !== 3'd2) begin
            errors++;
            $display("FAIL tie_lowest got chan=%0d exp chan=2", o7_chan);
        end
    endtask

    task automatic test_param_sweep();
        res_t obs;
        res_t exp;
        logic [55:0] sp;
        @(negedge clock);
        fill_random(127);
        set_sort_keys(5, 10, 3, 8, 20, 1, 15, 30);
        ch_en = 8'hFF; thr = '0; cand_vld = 1'b1;
        sp = pat;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clock);
            #1;
            if (e == 1) cand_vld = 1'b0;
            for (int id = 2; id <= 4; id++) begin
                exp = (e == lat_of(id)) ? model(n_of(id), 1'b1, 1'b1, sp, key, carry, 8'hFF, 7'd0)
                                        : res_t'('0);
                obs = observed(id);
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL sweep n=%0d edge=%0d got=%h exp=%h", n_of(id), e, obs, exp);
                end
            end
        end
        checks++;
        if (!(o2_chan === 1'b1 || o2_vld === 1'b0) || o5_chan !== 3'd0 || o8_chan !== 3'd0) begin
            errors++;
            $display("FAIL sweep_drain got c2=%0d c5=%0d c8=%0d exp 0", o2_chan, o5_chan, o8_chan);
        end
    endtask

    task automatic test_sweep_winners();
        @(negedge clock);
        fill_random(127);
        set_sort_keys(5, 10, 3, 8, 20, 1, 15, 30);
        ch_en = 8'hFF; thr = '0; cand_vld = 1'b1;
        fire_and_wait(2);
        checks++;
        if (o2_vld !== 1'b1 || o2_chan !== 1'b1) begin
            errors++;
            $display("FAIL n2_winner got vld=%b chan=%0d exp vld=1 chan=1", o2_vld, o2_chan);
        end
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (o5_chan !== 3'd4 || o8_chan !== 3'd7 || o8_key !== {3'd7, key[39:35]}) begin
            errors++;
            $display("FAIL odd_passthrough got c5=%0d c8=%0d k8=%h exp c5=4 c8=7 k8=%h",
                     o5_chan, o8_chan, o8_key, {3'd7, key[39:35]});
        end
    endtask

    task automatic test_back_to_back();
        logic        hv[32];
        logic [55:0] hp[32];
        logic [39:0] hk[32];
        logic [87:0] hc[32];
        logic [7:0]  he[32];
        logic [6:0]  ht[32];
        res_t        obs;
        res_t        exp;
        int          s;
        for (int t = 0; t < 24; t++) begin
            @(negedge clock);
            if (t < 20) begin
                fill_random(31);
                cand_vld = ($urandom_range(0, 3) != 0);
                ch_en    = 8'($urandom);
                thr      = 7'($urandom_range(0, 6));
            end else begin
                cand_vld = 1'b0;
            end
            hv[t] = cand_vld; hp[t] = pat; hk[t] = key; hc[t] = carry;
            he[t] = ch_en;    ht[t] = thr;
            @(posedge clock);
            #1;
            for (int id = 0; id < 5; id++) begin
                s = t - lat_of(id) + 1;
                if (s >= 0) begin
                    exp = model(n_of(id), ign_of(id), hv[s], hp[s], hk[s], hc[s], he[s], ht[s]);
                    obs = observed(id);
                    checks++;
                    if (obs !== exp) begin
                        errors++;
                        $display("FAIL stream n=%0d ign=%0d set=%0d got=%h exp=%h (vld|pat|key|carry|chan)",
                                 n_of(id), ign_of(id), s, obs, exp);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_select();
        test_mask_thresh();
        test_tie_lsb();
        test_param_sweep();
        test_sweep_winners();
        test_back_to_back();
        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
